// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl
//   Mode controller for the board LED blinker. Owns the clock-divide counter
//   and walks the LED through OFF, ON, SLOW blink, FAST blink and, when
//   enabled, a BURST of a fixed number of fast periods that ends in OFF.
//
//   Optional feature macro: LED_BLINK_CTRL_BURST_EN
//     defined   : BURST mode present, FAST -> BURST -> OFF on step
//     undefined : no BURST mode, FAST -> OFF on step, burst_done tied to 0
//
// Parameters
//   SLOW_HALF  slow-blink half-period in clk cycles (>= 1)
//   FAST_HALF  fast-blink / burst half-period in clk cycles (>= 1)
//   BURST_LEN  full on/off periods in a burst (>= 1)
//   CNT_W      divide counter width, holds max(SLOW_HALF, FAST_HALF) - 1
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   step        in   1-cycle pulse, advances the mode
//   hold        in   level, freezes counter, LED and burst count
//   led         out  registered LED drive
//   mode        out  current mode: OFF=0 ON=1 SLOW=2 FAST=3 BURST=4
//   tick        out  1-cycle pulse coincident with each new LED toggle value
//   burst_done  out  1-cycle pulse when a burst completes normally
module led_blink_ctrl #(
  parameter int SLOW_HALF = 50_000_000,
  parameter int FAST_HALF = 12_500_000,
  parameter int BURST_LEN = 3,
  parameter int CNT_W     = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       hold,
  output logic       led,
  output logic [2:0] mode,
  output logic       tick,
  output logic       burst_done
);

`ifdef LED_BLINK_CTRL_BURST_EN
  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_ON    = 3'd1,
    S_SLOW  = 3'd2,
    S_FAST  = 3'd3,
    S_BURST = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_ON   = 3'd1,
    S_SLOW = 3'd2,
    S_FAST = 3'd3
  } state_t;
`endif

  localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(SLOW_HALF - 1);
  localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(FAST_HALF - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_led;
  logic             r_tick;
  logic             r_burst_done;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_led_nxt;
  logic             w_tick_nxt;
  logic             w_burst_done_nxt;
  logic             w_blink;
  logic [CNT_W-1:0] w_half_m1;
  logic             w_tc;

`ifdef LED_BLINK_CTRL_BURST_EN
  localparam int              BCNT_W        = $clog2(2 * BURST_LEN + 1);
  localparam logic [BCNT_W-1:0] BURST_TOGGLES = BCNT_W'(2 * BURST_LEN);

  logic [BCNT_W-1:0] r_bcnt;
  logic [BCNT_W-1:0] w_bcnt_nxt;
  logic [BCNT_W-1:0] w_bcnt_inc;

  assign w_blink    = (r_state == S_SLOW) || (r_state == S_FAST) ||
                      (r_state == S_BURST);
  assign w_bcnt_inc = r_bcnt + BCNT_W'(1);
`else
  // BURST_LEN has no meaning without the burst feature.
  logic w_unused_burst_len;
  assign w_unused_burst_len = (BURST_LEN != 0);

  assign w_blink = (r_state == S_SLOW) || (r_state == S_FAST);
`endif

  assign w_half_m1 = (r_state == S_SLOW) ? SLOW_M1 : FAST_M1;
  assign w_tc      = w_blink && (r_cnt == w_half_m1);

  // Next-state / next-output logic. Priority: step, hold, terminal count.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_led_nxt        = r_led;
    w_tick_nxt       = 1'b0;
    w_burst_done_nxt = 1'b0;
`ifdef LED_BLINK_CTRL_BURST_EN
    w_bcnt_nxt       = r_bcnt;
`endif

    if (step) begin
      case (r_state)
        S_OFF:   w_state_nxt = S_ON;
        S_ON:    w_state_nxt = S_SLOW;
        S_SLOW:  w_state_nxt = S_FAST;
`ifdef LED_BLINK_CTRL_BURST_EN
        S_FAST:  w_state_nxt = S_BURST;
        S_BURST: w_state_nxt = S_OFF;   // abort, no burst_done
`else
        S_FAST:  w_state_nxt = S_OFF;
`endif
        default: w_state_nxt = S_OFF;
      endcase
      // Mode entry: fresh count, LED forced to the mode's entry level,
      // and no tick even if this was a terminal-count cycle.
      w_cnt_nxt = '0;
      w_led_nxt = (w_state_nxt != S_OFF);
`ifdef LED_BLINK_CTRL_BURST_EN
      w_bcnt_nxt = '0;
`endif
    end else if (!hold && w_blink) begin
      if (w_tc) begin
        w_cnt_nxt  = '0;
        w_led_nxt  = ~r_led;
        w_tick_nxt = 1'b1;
`ifdef LED_BLINK_CTRL_BURST_EN
        if (r_state == S_BURST) begin
          w_bcnt_nxt = w_bcnt_inc;
          // An even number of toggles from led=1 leaves the LED at 0,
          // which is also the OFF entry level.
          if (w_bcnt_inc == BURST_TOGGLES) begin
            w_state_nxt      = S_OFF;
            w_burst_done_nxt = 1'b1;
            w_bcnt_nxt       = '0;
          end
        end
`endif
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_OFF;
      r_cnt        <= '0;
      r_led        <= 1'b0;
      r_tick       <= 1'b0;
      r_burst_done <= 1'b0;
`ifdef LED_BLINK_CTRL_BURST_EN
      r_bcnt       <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_led        <= w_led_nxt;
      r_tick       <= w_tick_nxt;
      r_burst_done <= w_burst_done_nxt;
`ifdef LED_BLINK_CTRL_BURST_EN
      r_bcnt       <= w_bcnt_nxt;
`endif
    end
  end

  assign led        = r_led;
  assign mode       = r_state;
  assign tick       = r_tick;
  assign burst_done = r_burst_done;

endmodule
